imm_gen_pipe: RTL
=================

Name: imm_gen_pipe

Overview:
- Parametrised, pipelined immediate generator for the decode stage of the segmented RISC-V core.
- Takes the full 32-bit instruction plus the ImmSrc format select from the control unit.
- Produces an XLEN-wide sign/zero-extended immediate after a configurable register latency, with valid, stall and flush control matching the pipeline registers.
- Adds shift-amount handling restricted to OP-IMM opcodes, RV64 widths, and an illegal-format flag.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64
STAGES, 1, register latency from input to output; legal values 1 or 2
SHAMT_W, $clog2(XLEN), shift-amount width (5 or 6); derived, not overridden

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
InValid  input  1  Inst/ImmSrc valid this cycle
Stall  input  1  hold all stage registers
Flush  input  1  kill all in-flight entries
Inst  input  32  full instruction word
ImmSrc  input  3  format: 000 I, 001 S, 101 B, 010 U, 110 J
ImmExt  output  XLEN  extended immediate
OutValid  output  1  ImmExt/ImmIllegal valid
ImmIllegal  output  1  ImmSrc was an unused encoding

Behaviour:
- One clock (clk). Reset is synchronous and active-high: on a clk edge with reset=1, every stage valid clears to 0 and every stage data register clears to 0. After reset, OutValid=0, ImmExt=0, ImmIllegal=0.
- Combinational decode, sign bit s=Inst[31]; each result is sign-extended to XLEN:
  - I: Inst[31:20].
  - I-shift, when ImmSrc=000, Inst[6:0] is 0010011 or 0011011, and Inst[14:12] is 001 or 101: zero-extended Inst[20+SHAMT_W-1:20]. For opcode 0011011 (OP-IMM-32) the field is always 5 bits.
  - Loads with funct3 001/101 use plain I-type. They are not treated as shifts.
  - S: {Inst[31:25], Inst[11:7]}.
  - B: {Inst[31], Inst[7], Inst[30:25], Inst[11:8], 0}.
  - U: {Inst[31:12], 12'b0}, sign-extended from bit 31 (relevant when XLEN=64).
  - J: {Inst[31], Inst[19:12], Inst[20], Inst[30:21], 0}.
  - Other ImmSrc (011, 100, 111): result 0, ImmIllegal=1.
- Pipeline: STAGES register stages, each holding {valid, imm, illegal}.
  - Stage 1 captures {InValid, decode}.
  - Stage k captures stage k-1.
  - The outputs are the last stage, so latency is exactly STAGES cycles.
- Per clk edge, in priority order:
  1. reset: clear everything.
  2. Flush: all valids cleared to 0 (data may stay); Flush overrides Stall; any input presented that cycle is dropped.
  3. Stall: every stage holds valid and data; the input is not captured.
  4. Otherwise: shift one stage.
- When a stage captures with valid=0, its data registers hold their previous value, so ImmExt is stable while OutValid=0.
- No backpressure output. The upstream stall logic drives Stall to the whole pipeline, including this block.
- Stall and Flush asserted together: Flush wins; no entries remain valid.
- Reset asserted mid-stream: all entries are lost, and OutValid=0 on the next cycle.

Test Plan:
1. XLEN=32, STAGES=1. Inst=0xFFF00093 (addi), ImmSrc=000, InValid=1 -> next cycle ImmExt=0xFFFFFFFF, OutValid=1, ImmIllegal=0.
2. Inst=0x40315093 (srai x1,x2,3), ImmSrc=000 -> ImmExt=0x00000003. Then Inst=0xFFC15083 (lhu, imm -4), ImmSrc=000 -> ImmExt=0xFFFFFFFC (not a shamt).
3. Inst=0xFE000CE3 (beq offset -8), ImmSrc=101 -> ImmExt=0xFFFFFFF8. Then same Inst with ImmSrc=011 -> ImmExt=0, ImmIllegal=1.
4. XLEN=64. Inst=0x80000537 (lui), ImmSrc=010 -> ImmExt=0xFFFFFFFF80000000. Then Inst=0x03F11093 (slli by 63), ImmSrc=000 -> ImmExt=0x000000000000003F.
5. STAGES=2. Issue entries A, B on back-to-back cycles, then raise Stall for 2 cycles after B enters -> A held at the output for 3 cycles total, B appears on the cycle after Stall drops, and no duplicates or drops occur.
6. STAGES=2. With 2 entries in flight, assert Flush and Stall together for 1 cycle -> OutValid=0 on the following 2 cycles. Separately, assert reset mid-stream -> OutValid=0, ImmExt=0 on the next cycle.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator for the decode stage.
// Decodes the immediate of a 32-bit instruction according to the ImmSrc
// format select, then carries {valid, imm, illegal} through STAGES registers
// that share the Stall/Flush controls of the surrounding pipeline.
//
// Handshake: InValid qualifies Inst/ImmSrc in the cycle it is high and
// OutValid qualifies ImmExt/ImmIllegal. There is no ready; the block never
// pushes back. Upstream hazard logic holds the whole pipe with Stall and
// drops in-flight work with Flush. Flush wins over Stall, and an input
// presented during a Stall or Flush cycle is not captured.
module imm_gen_pipe #(
    parameter int XLEN   = 32,
    parameter int STAGES = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            InValid,
    input  logic            Stall,
    input  logic            Flush,
    input  logic [31:0]     Inst,
    input  logic [2:0]      ImmSrc,
    output logic [XLEN-1:0] ImmExt,
    output logic            OutValid,
    output logic            ImmIllegal
);

    localparam int SHAMT_W = $clog2(XLEN);

    localparam logic [2:0] SRC_I = 3'b000;
    localparam logic [2:0] SRC_S = 3'b001;
    localparam logic [2:0] SRC_B = 3'b101;
    localparam logic [2:0] SRC_U = 3'b010;
    localparam logic [2:0] SRC_J = 3'b110;

    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;

    // Combinational decode results feeding stage 1.
    logic [XLEN-1:0] dec_imm;
    logic            dec_illegal;
    logic [31:0]     raw;        // 32-bit sign-carrying immediate before widening
    logic            is_op_imm;
    logic            is_op_imm32;
    logic            is_shift_f3;

    // Per-stage registers; index STAGES-1 drives the outputs.
    logic            vld_q [STAGES];
    logic [XLEN-1:0] imm_q [STAGES];
    logic            ill_q [STAGES];

    // Decode the immediate for the selected format and widen it to XLEN.
    always_comb begin
        dec_imm     = '0;
        dec_illegal = 1'b0;
        raw         = '0;
        is_op_imm   = (Inst[6:0] == OPC_OP_IMM);
        is_op_imm32 = (Inst[6:0] == OPC_OP_IMM_32);
        is_shift_f3 = (Inst[14:12] == 3'b001) || (Inst[14:12] == 3'b101);

        case (ImmSrc)
            SRC_I: raw = {{20{Inst[31]}}, Inst[31:20]};
            SRC_S: raw = {{20{Inst[31]}}, Inst[31:25], Inst[11:7]};
            SRC_B: raw = {{19{Inst[31]}}, Inst[31], Inst[7], Inst[30:25], Inst[11:8], 1'b0};
            SRC_U: raw = {Inst[31:12], 12'b0};
            SRC_J: raw = {{11{Inst[31]}}, Inst[31], Inst[19:12], Inst[20], Inst[30:21], 1'b0};
            default: begin
                raw         = '0;
                dec_illegal = 1'b1;
            end
        endcase

        // All legal formats carry their sign in raw[31]; extend it to XLEN.
        dec_imm = {{(XLEN-31){raw[31]}}, raw[30:0]};

        // Shift immediates only exist on OP-IMM / OP-IMM-32 with funct3 001/101.
        // Loads share the I format and funct3 values, so the opcode check matters.
        // The word-sized shifts of OP-IMM-32 always use a 5-bit amount.
        if (ImmSrc == SRC_I && is_shift_f3) begin
            if (is_op_imm32) begin
                dec_imm = XLEN'(Inst[24:20]);
            end else if (is_op_imm) begin
                dec_imm = XLEN'(Inst[20+SHAMT_W-1:20]);
            end
        end
    end

    // Stage registers: reset clears all, Flush kills valids, Stall holds, else shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= 1'b0;
                imm_q[k] <= '0;
                ill_q[k] <= 1'b0;
            end
        end else if (Flush) begin
            // Data is left in place; only the valids matter after a flush.
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= 1'b0;
            end
        end else if (!Stall) begin
            vld_q[0] <= InValid;
            if (InValid) begin
                imm_q[0] <= dec_imm;
                ill_q[0] <= dec_illegal;
            end
            // A bubble leaves the downstream data untouched so ImmExt stays
            // stable while OutValid is low.
            for (int k = 1; k < STAGES; k++) begin
                vld_q[k] <= vld_q[k-1];
                if (vld_q[k-1]) begin
                    imm_q[k] <= imm_q[k-1];
                    ill_q[k] <= ill_q[k-1];
                end
            end
        end
    end

    assign ImmExt     = imm_q[STAGES-1];
    assign OutValid   = vld_q[STAGES-1];
    assign ImmIllegal = ill_q[STAGES-1];

endmodule
